// File: rtl/burst_ram_arbiter.sv
// Two-port burst arbiter in front of one BurstRAM; holds the grant for a whole burst.
// Optional macro BURST_RAM_ARBITER_PRIORITY_A_EN: port A always wins simultaneous requests.
module burst_ram_arbiter #(
    parameter int unsigned DEPTH_BITWIDTH = 8,
    parameter int unsigned DATA_BITWIDTH  = 64,
    parameter int unsigned BURST_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          a_cmd,
    input  logic                          a_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     a_addr,
    input  logic [DATA_BITWIDTH-1:0]      a_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    a_data_mask,
    output logic [DATA_BITWIDTH-1:0]      a_rd_data,
    output logic                          a_rd_data_valid,
    output logic                          a_busy,

    input  logic                          b_cmd,
    input  logic                          b_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     b_addr,
    input  logic [DATA_BITWIDTH-1:0]      b_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    b_data_mask,
    output logic [DATA_BITWIDTH-1:0]      b_rd_data,
    output logic                          b_rd_data_valid,
    output logic                          b_busy,

    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]     br_addr,
    output logic [DATA_BITWIDTH-1:0]      br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]    br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
    input  logic                          br_rd_data_valid,
    input  logic                          br_busy
);

    localparam int unsigned CNT_W = $clog2(BURST_COUNT);
    localparam logic [CNT_W-1:0] LAST_WR_CNT = CNT_W'(BURST_COUNT - 2);
    localparam logic [CNT_W-1:0] LAST_RD_CNT = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    state_e            state_q, state_d;
    port_e             own_q, own_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             winner;
    port_e             sel;
    logic              any_req;
    logic              accept;
    logic              idle_grant;
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
    port_e             rr_q, rr_d;
`endif

    assign any_req = a_cmd_en | b_cmd_en;

    // Winner of this cycle's arbitration; defaults to A with no requests.
    always_comb begin
        winner = PORT_A;
        if (b_cmd_en && !a_cmd_en) begin
            winner = PORT_B;
        end
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
        else if (a_cmd_en && b_cmd_en) begin
            winner = rr_q;
        end
`endif
    end

    // Data path follows the winner while idle, the owner during a burst.
    assign sel          = (state_q == IDLE) ? winner : own_q;
    assign br_cmd       = (sel == PORT_A) ? a_cmd       : b_cmd;
    assign br_addr      = (sel == PORT_A) ? a_addr      : b_addr;
    assign br_wr_data   = (sel == PORT_A) ? a_wr_data   : b_wr_data;
    assign br_data_mask = (sel == PORT_A) ? a_data_mask : b_data_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= PORT_A;
            cnt_q   <= '0;
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
            rr_q    <= PORT_A;
`endif
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req && !br_busy) begin
                    accept  = 1'b1;
                    own_d   = winner;
                    cnt_d   = '0;
                    state_d = br_cmd ? WRITE : READ;
`ifndef BURST_RAM_ARBITER_PRIORITY_A_EN
                    rr_d    = (winner == PORT_A) ? PORT_B : PORT_A;
`endif
                end
            end
            WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WR_CNT) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (br_rd_data_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_RD_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are combinational and forced safe while reset is held.
    assign idle_grant = rst && (state_q == IDLE) && !br_busy;
    assign br_cmd_en  = rst && accept;
    assign a_busy     = !(idle_grant && (winner == PORT_A));
    assign b_busy     = !(idle_grant && (winner == PORT_B));

    assign a_rd_data       = br_rd_data;
    assign b_rd_data       = br_rd_data;
    assign a_rd_data_valid = rst && (state_q == READ) && (own_q == PORT_A) && br_rd_data_valid;
    assign b_rd_data_valid = rst && (state_q == READ) && (own_q == PORT_B) && br_rd_data_valid;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: directed scenarios plus random traffic vs a burst-level model.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned XW = 64;
    localparam int unsigned BC = 4;
    localparam int unsigned MW = XW / 8;

    typedef struct {
        logic          cmd;
        logic [DW-1:0] addr;
    } req_t;

    typedef struct {
        int            port;
        logic          cmd;
        logic [DW-1:0] addr;
        int            cyc;
    } grant_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_cmd, b_cmd, a_cmd_en, b_cmd_en;
    logic [DW-1:0] a_addr, b_addr;
    logic [XW-1:0] a_wr_data, b_wr_data;
    logic [MW-1:0] a_data_mask, b_data_mask;
    logic [XW-1:0] a_rd_data, b_rd_data;
    logic          a_rd_data_valid, b_rd_data_valid, a_busy, b_busy;
    logic          br_cmd, br_cmd_en;
    logic [DW-1:0] br_addr;
    logic [XW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [XW-1:0] br_rd_data;
    logic          br_rd_data_valid, br_busy;

    always #5 clk = ~clk;

    burst_ram_arbiter #(
        .DEPTH_BITWIDTH(DW),
        .DATA_BITWIDTH (XW),
        .BURST_COUNT   (BC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .a_cmd           (a_cmd),
        .a_cmd_en        (a_cmd_en),
        .a_addr          (a_addr),
        .a_wr_data       (a_wr_data),
        .a_data_mask     (a_data_mask),
        .a_rd_data       (a_rd_data),
        .a_rd_data_valid (a_rd_data_valid),
        .a_busy          (a_busy),
        .b_cmd           (b_cmd),
        .b_cmd_en        (b_cmd_en),
        .b_addr          (b_addr),
        .b_wr_data       (b_wr_data),
        .b_data_mask     (b_data_mask),
        .b_rd_data       (b_rd_data),
        .b_rd_data_valid (b_rd_data_valid),
        .b_busy          (b_busy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (br_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    req_t   rq0[$];
    req_t   rq1[$];
    grant_t glog[$];

    logic          dr_cmd[2];
    logic          dr_en[2];
    logic [DW-1:0] dr_addr[2];
    logic [XW-1:0] dr_data[2];
    logic [MW-1:0] dr_mask[2];
    int            wb[2];
    logic [DW-1:0] wa[2];
    int            rcv[2];

    // Burst-level model: who owns the RAM and how many beats remain.
    int            m_owner = -1;
    logic          m_write = 1'b0;
    logic [DW-1:0] m_addr  = '0;
    int            m_left  = 0;
    int            m_rr    = 0;
    bit            p_acc;
    int            p_win;

    int ram_pending = 0;
    int ram_lat     = 0;
    bit ram_hold    = 1'b0;
    bit force_busy  = 1'b0;
    bit rand_mode   = 1'b0;
    int en_seen     = 0;

    function automatic logic [XW-1:0] beat_data(int p, logic [DW-1:0] addr, int k);
        return {4'(p + 1), 4'(k), {6{addr}}, 8'hA5};
    endfunction

    function automatic logic [MW-1:0] beat_mask(int p, logic [DW-1:0] addr, int k);
        return MW'(p * 16 + k + 1) ^ MW'(addr);
    endfunction

    function automatic int q_size(int p);
        if (p == 0) return rq0.size();
        return rq1.size();
    endfunction

    function automatic req_t q_front(int p);
        if (p == 0) return rq0[0];
        return rq1[0];
    endfunction

    function automatic void q_pop(int p);
        if (p == 0) void'(rq0.pop_front());
        else        void'(rq1.pop_front());
    endfunction

    function automatic void q_push(int p, logic cmd, logic [DW-1:0] addr);
        req_t r;
        r.cmd  = cmd;
        r.addr = addr;
        if (p == 0) rq0.push_back(r);
        else        rq1.push_back(r);
    endfunction

    function automatic bit quiet();
        return (m_owner < 0) && (rq0.size() == 0) && (rq1.size() == 0) &&
               (wb[0] == 0) && (wb[1] == 0) && (ram_pending == 0);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Requesters and RAM responder drive their inputs just after the clock edge.
    task automatic drive();
        req_t r;
        for (int p = 0; p < 2; p++) begin
            if (wb[p] > 0) begin
                dr_en[p]   = 1'b0;
                dr_cmd[p]  = 1'($urandom);
                dr_addr[p] = wa[p];
                dr_data[p] = beat_data(p, wa[p], BC - wb[p]);
                dr_mask[p] = beat_mask(p, wa[p], BC - wb[p]);
            end else if (q_size(p) > 0) begin
                r          = q_front(p);
                dr_en[p]   = 1'b1;
                dr_cmd[p]  = r.cmd;
                dr_addr[p] = r.addr;
                dr_data[p] = beat_data(p, r.addr, 0);
                dr_mask[p] = beat_mask(p, r.addr, 0);
            end else begin
                dr_en[p]   = 1'b0;
                dr_cmd[p]  = 1'($urandom);
                dr_addr[p] = DW'($urandom);
                dr_data[p] = {$urandom, $urandom};
                dr_mask[p] = MW'($urandom);
            end
        end
        a_cmd = dr_cmd[0]; a_cmd_en = dr_en[0]; a_addr = dr_addr[0];
        a_wr_data = dr_data[0]; a_data_mask = dr_mask[0];
        b_cmd = dr_cmd[1]; b_cmd_en = dr_en[1]; b_addr = dr_addr[1];
        b_wr_data = dr_data[1]; b_data_mask = dr_mask[1];
        br_busy = force_busy || (rand_mode && ($urandom_range(0, 3) == 0));
        br_rd_data = {$urandom, $urandom};
        br_rd_data_valid = !ram_hold && (ram_pending > 0) && (ram_lat == 0) &&
                           !(rand_mode && ($urandom_range(0, 2) == 0));
        if (ram_lat > 0) ram_lat--;
    endtask

    // Predict every DUT output from the model and the driven inputs.
    task automatic evaluate();
        int   win;
        bit   acc;
        logic e_av, e_bv;
        win = 0;
        if (dr_en[1] && !dr_en[0]) begin
            win = 1;
        end else if (dr_en[0] && dr_en[1]) begin
`ifdef BURST_RAM_ARBITER_PRIORITY_A_EN
            win = 0;
`else
            win = m_rr;
`endif
        end
        acc = rst && (m_owner < 0) && (dr_en[0] || dr_en[1]) && !br_busy;
        check("a_busy", 64'(a_busy), 64'(!(rst && m_owner < 0 && !br_busy && win == 0)));
        check("b_busy", 64'(b_busy), 64'(!(rst && m_owner < 0 && !br_busy && win == 1)));
        check("br_cmd_en", 64'(br_cmd_en), 64'(acc));
        if (acc) begin
            check("br_cmd", 64'(br_cmd), 64'(dr_cmd[win]));
            check("br_addr", 64'(br_addr), 64'(dr_addr[win]));
            if (dr_cmd[win]) begin
                check("br_wr_beat0", br_wr_data, beat_data(win, dr_addr[win], 0));
                check("br_mask_beat0", 64'(br_data_mask), 64'(beat_mask(win, dr_addr[win], 0)));
            end
        end
        if (rst && m_owner >= 0 && m_write) begin
            check("br_wr_beat", br_wr_data, beat_data(m_owner, m_addr, BC - m_left));
            check("br_mask_beat", 64'(br_data_mask), 64'(beat_mask(m_owner, m_addr, BC - m_left)));
        end
        e_av = rst && (m_owner == 0) && !m_write && br_rd_data_valid;
        e_bv = rst && (m_owner == 1) && !m_write && br_rd_data_valid;
        check("a_rd_valid", 64'(a_rd_data_valid), 64'(e_av));
        check("b_rd_valid", 64'(b_rd_data_valid), 64'(e_bv));
        check("a_rd_data", a_rd_data, br_rd_data);
        check("b_rd_data", b_rd_data, br_rd_data);
        if (a_rd_data_valid === 1'b1) rcv[0]++;
        if (b_rd_data_valid === 1'b1) rcv[1]++;
        if (br_cmd_en === 1'b1) en_seen++;
        p_acc = acc;
        p_win = win;
    endtask

    task automatic commit();
        grant_t g;
        cyc++;
        if (br_rd_data_valid && ram_pending > 0) ram_pending--;
        for (int p = 0; p < 2; p++) if (wb[p] > 0) wb[p]--;
        if (!rst) begin
            m_owner = -1;
            m_left  = 0;
            m_rr    = 0;
        end else if (p_acc) begin
            m_owner = p_win;
            m_write = dr_cmd[p_win];
            m_addr  = dr_addr[p_win];
            m_left  = m_write ? BC - 1 : BC;
            m_rr    = 1 - p_win;
            g.port = p_win; g.cmd = dr_cmd[p_win]; g.addr = dr_addr[p_win]; g.cyc = cyc;
            glog.push_back(g);
            q_pop(p_win);
            if (m_write) begin
                wb[p_win] = BC - 1;
                wa[p_win] = m_addr;
            end else begin
                if (ram_pending == 0) ram_lat = rand_mode ? int'($urandom_range(0, 4)) : 2;
                ram_pending += BC;
            end
        end else if (m_owner >= 0) begin
            if (m_write || br_rd_data_valid) m_left--;
            if (m_left == 0) m_owner = -1;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        evaluate();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic run_quiet(string tag, int max);
        int k = 0;
        while (!quiet() && k < max) begin
            step();
            k++;
        end
        check_int({tag, "_done"}, int'(quiet()), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic check_seq(string tag, int base, int n, int e0, int e1, int e2, int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check_int({tag, "_count"}, glog.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < glog.size()) check_int({tag, "_port"}, glog[base + i].port, e[i]);
        end
    endtask

    initial begin
        int base, r0, r1, en0, k, reads0, reads1;
        for (int p = 0; p < 2; p++) begin
            wb[p] = 0; wa[p] = '0; rcv[p] = 0;
        end

        // Reset: outputs forced while held.
        rst = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();

        // Single read on A at 0x10.
        base = glog.size(); r0 = rcv[0]; r1 = rcv[1]; en0 = en_seen;
        q_push(0, 1'b0, 8'h10);
        run_quiet("t1", 100);
        check_seq("t1", base, 1, 0, 0, 0, 0);
        if (glog.size() > base) begin
            check("t1_addr", 64'(glog[base].addr), 64'h10);
            check("t1_cmd", 64'(glog[base].cmd), 64'h0);
        end
        check_int("t1_en_pulses", en_seen - en0, 1);
        check_int("t1_a_beats", rcv[0] - r0, BC);
        check_int("t1_b_beats", rcv[1] - r1, 0);

        // A write and B read together right after reset.
        do_reset();
        base = glog.size(); r1 = rcv[1];
        q_push(0, 1'b1, 8'h20);
        q_push(1, 1'b0, 8'h30);
        run_quiet("t2", 100);
        check_seq("t2", base, 2, 0, 1, 0, 0);
        if (glog.size() >= base + 2) begin
            check("t2_a_write", 64'(glog[base].cmd), 64'h1);
            check_int("t2_b_gap", glog[base + 1].cyc - glog[base].cyc, BC);
        end
        check_int("t2_b_beats", rcv[1] - r1, BC);

        // Both ports issuing reads back to back.
        do_reset();
        base = glog.size(); r0 = rcv[0]; r1 = rcv[1];
        q_push(0, 1'b0, 8'h01); q_push(0, 1'b0, 8'h02);
        q_push(1, 1'b0, 8'h81); q_push(1, 1'b0, 8'h82);
        run_quiet("t3", 200);
`ifdef BURST_RAM_ARBITER_PRIORITY_A_EN
        check_seq("t3", base, 4, 0, 0, 1, 1);
`else
        check_seq("t3", base, 4, 0, 1, 0, 1);
`endif
        check_int("t3_a_beats", rcv[0] - r0, 2 * BC);
        check_int("t3_b_beats", rcv[1] - r1, 2 * BC);

        // RAM busy holds off both requesters.
        do_reset();
        base = glog.size(); en0 = en_seen;
        force_busy = 1'b1;
        q_push(0, 1'b0, 8'h44);
        q_push(1, 1'b0, 8'h55);
        step(); step(); step();
        check_int("t4_no_grant", glog.size() - base, 0);
        check_int("t4_no_en", en_seen - en0, 0);
        force_busy = 1'b0;
        step();
        check_seq("t4_release", base, 1, 0, 0, 0, 0);
        run_quiet("t4", 100);

        // Reset in the middle of a read burst drops the late beats.
        do_reset();
        r0 = rcv[0]; r1 = rcv[1];
        q_push(0, 1'b0, 8'h66);
        k = 0;
        while ((rcv[0] - r0) < 2 && k < 50) begin
            step();
            k++;
        end
        check_int("t5_early_beats", rcv[0] - r0, 2);
        ram_hold = 1'b1;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        ram_hold = 1'b0;
        run_quiet("t5", 100);
        check_int("t5_a_beats", rcv[0] - r0, 2);
        check_int("t5_b_beats", rcv[1] - r1, 0);

        // A keeps requesting while B waits.
        do_reset();
        base = glog.size();
        q_push(0, 1'b0, 8'h0A); q_push(0, 1'b0, 8'h0B); q_push(0, 1'b0, 8'h0C);
        q_push(1, 1'b0, 8'hB0);
        run_quiet("t6", 300);
`ifdef BURST_RAM_ARBITER_PRIORITY_A_EN
        check_seq("t6", base, 4, 0, 0, 0, 1);
`else
        check_seq("t6", base, 4, 0, 1, 0, 0);
`endif

        // Random traffic with random RAM stalls and read latency.
        do_reset();
        base = glog.size(); r0 = rcv[0]; r1 = rcv[1];
        rand_mode = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (q_size(p) < 2 && $urandom_range(0, 3) == 0) q_push(p, 1'($urandom), DW'($urandom));
            end
            step();
        end
        run_quiet("rand", 500);
        reads0 = 0; reads1 = 0;
        for (int i = base; i < glog.size(); i++) begin
            if (!glog[i].cmd && glog[i].port == 0) reads0++;
            if (!glog[i].cmd && glog[i].port == 1) reads1++;
        end
        check_int("rand_a_beats", rcv[0] - r0, reads0 * BC);
        check_int("rand_b_beats", rcv[1] - r1, reads1 * BC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
